usb_fs_rx_phy: RTL and testbench
================================

Name: usb_fs_rx_phy

Overview:
- USB full-speed receive front end. Sits directly downstream of the D+/D- pad mux and consumes its dp_rx/dn_rx outputs.
- Per packet: oversamples the line 4x at 48 MHz, recovers bit timing, decodes NRZI, detects SYNC, removes stuffed bits, assembles LSB-first bytes, and detects EOP.
- Output is a byte stream with packet start, end and error strobes, consumed by the packet decoder.

Parameters:
- SAMPLE_PHASE, 2, phase-counter value (0..3) at which a bit is sampled; 2 = mid-bit.
- SYNC_ZEROS, 3, minimum consecutive decoded 0s before the terminating 1 to accept SYNC.
- STUFF_ONES, 6, consecutive 1s after which the next bit is a stuffed 0.
- IDLE_EXIT_J, 8, consecutive J samples that release the ERROR state.

Ports:
- clk  in  1  48 MHz clock.
- reset_n  in  1  synchronous, active-low reset.
- dp_rx  in  1  D+ receive value from the pad mux; asynchronous to clk.
- dn_rx  in  1  D- receive value from the pad mux; asynchronous to clk.
- rx_active  out  1  high from pkt_start through pkt_end/pkt_err.
- pkt_start  out  1  one-cycle pulse when SYNC is accepted.
- pkt_end  out  1  one-cycle pulse on completion of a valid EOP.
- pkt_err  out  1  one-cycle pulse on a stuff, line or alignment error.
- data  out  8  last assembled byte, LSB = first received bit; held until the next byte.
- data_valid  out  1  one-cycle pulse when data is updated.

Behaviour:
- Clocking and reset: one clock, clk. reset_n is synchronous and active-low. All outputs reset to 0; state = IDLE; phase = 0; previous line state = J.
- Input synchronisation: dp_rx and dn_rx each pass through a 2-flop synchroniser, then are decoded to line state J (1,0), K (0,1), SE0 (0,0) or SE1 (1,1).
- DPLL:
  - 2-bit phase counter, incremented modulo 4 every cycle.
  - When the synchronised line state differs from the previous cycle's state, phase loads 0 that cycle.
  - Sample strobe asserts when phase == SAMPLE_PHASE.
  - Latency: pad edge to first sample is 2 sync cycles + SAMPLE_PHASE + 1 cycles.
- NRZI decode (sampled J/K only): decoded bit = 1 if the sample equals the previous J/K sample, else 0. The previous sample updates on every J/K sample.
- IDLE:
  - Sampled K -> SYNC; zero count = 1.
  - SE0/SE1 samples are ignored.
- SYNC:
  - Decoded 0: increment zero count (saturate at 7).
  - Decoded 1 with zero count >= SYNC_ZEROS: -> DATA; pulse pkt_start; set rx_active; clear bit counter and ones counter.
  - Decoded 1 with fewer zeros: -> IDLE.
  - SE0 sample: -> IDLE, no pulse.
- DATA, per J/K sample:
  - If the ones counter == STUFF_ONES:
    - Decoded 0 is dropped and the ones counter clears.
    - Decoded 1 causes pkt_err, -> ERROR.
  - Otherwise:
    - The bit shifts into the byte register at the MSB (right shift), bit counter increments, and the ones counter increments on 1 or clears on 0.
    - On the 8th bit (counter wraps 7 -> 0), pulse data_valid with the full byte in the same cycle.
- DATA, other samples:
  - SE0 sample -> EOP; the SE0 is not a data bit.
  - SE1 sample -> pkt_err, -> ERROR.
- EOP:
  - Further SE0 samples hold the state.
  - J sample:
    - If the bit counter == 0, pulse pkt_end.
    - Otherwise pulse pkt_err (misaligned) and do not pulse pkt_end.
    - Either way -> IDLE.
  - K or SE1 sample: pkt_err, -> IDLE.
- ERROR:
  - Clear rx_active.
  - Exit to IDLE on a completed SE0 -> J sequence, or after IDLE_EXIT_J consecutive J samples.
- Pulse exclusivity:
  - pkt_end and pkt_err never assert in the same cycle.
  - data_valid never coincides with pkt_end.
- rx_active clears in the same cycle as pkt_end or pkt_err.
- reset_n low mid-packet: all state clears next edge; no pulses emitted.
- Long SE0 (bus reset) while in IDLE: no output activity.

Decomposition:
- Package usb_fs_rx_pkg:
  - Line-state encodings J/K/SE0/SE1.
  - rx_state enum IDLE/SYNC/DATA/EOP/ERROR.
  - Full-speed oversample ratio constant 4.
- One sub-module, usb_fs_rx_linesync: the 2-flop synchronisers plus line-state decode, outputting registered line_state[1:0].
- DPLL, NRZI, unstuff and byte logic stay in the top.

Test Plan:
- SYNC plus byte 0xA5 plus 2-bit SE0 EOP, ideal 4-cycle bit period -> pkt_start once; data_valid once with data = 0xA5; then pkt_end; rx_active high throughout.
- Data byte 0xFF (6 ones then a stuffed 0, then 2 more ones) -> stuffed bit dropped; data_valid with 0xFF; pkt_end; no pkt_err.
- Seven consecutive decoded 1s in DATA -> pkt_err on the 7th bit sample; rx_active = 0; no pkt_end; then 8 J bit-times -> returns to IDLE and accepts the next packet.
- 12-bit payload then EOP -> one data_valid, then pkt_err at EOP J with pkt_end low.
- Bit period jittered 3/5 cycles alternating across a 3-byte packet 0x01,0x80,0x3C -> all three bytes correct, pkt_end.
- reset_n asserted for 1 cycle mid-byte -> all outputs 0 next cycle; SE0 held for 30000 cycles afterwards -> no pulses.

Source files
------------

// File: rtl/usb_fs_rx_pkg.sv
// usb_fs_rx_pkg: line-state encodings, receiver states and oversampling constant
package usb_fs_rx_pkg;
    localparam int OVERSAMPLE = 4;
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;
    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ERROR} rx_state_t;
endpackage

// File: rtl/usb_fs_rx_linesync.sv
// usb_fs_rx_linesync: two-flop synchronisers for D+/D- producing the registered {dp,dn} line state
module usb_fs_rx_linesync
    import usb_fs_rx_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dp_rx,
    input  logic       dn_rx,
    output logic [1:0] line_state
);
    logic [1:0] meta;
    // first stage absorbs metastability, second stage is the usable line state (idles at J)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta       <= LS_J;
            line_state <= LS_J;
        end else begin
            meta       <= {dp_rx, dn_rx};
            line_state <= meta;
        end
    end
endmodule

// File: rtl/usb_fs_rx_phy.sv
// usb_fs_rx_phy: full-speed receive front end (DPLL, NRZI, SYNC, unstuffing, byte assembly, EOP)
module usb_fs_rx_phy
    import usb_fs_rx_pkg::*;
#(
    parameter int SAMPLE_PHASE = 2,
    parameter int SYNC_ZEROS   = 3,
    parameter int STUFF_ONES   = 6,
    parameter int IDLE_EXIT_J  = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dp_rx,
    input  logic       dn_rx,
    output logic       rx_active,
    output logic       pkt_start,
    output logic       pkt_end,
    output logic       pkt_err,
    output logic [7:0] data,
    output logic       data_valid
);
    logic [1:0] line, line_prev_q, jk_prev_q, phase_q, phase;
    rx_state_t  state_q, state_d;
    logic [2:0] zeros_q, zeros_d, ones_q, ones_d, bits_q, bits_d;
    logic [7:0] sr_q, sr_d, data_d;
    logic [3:0] jcnt_q, jcnt_d;
    logic       se0_seen_q, se0_seen_d;
    logic       sample, jk, nrzi_bit;
    logic       active_d, start_d, end_d, err_d, valid_d;

    usb_fs_rx_linesync u_linesync (
        .clk        (clk),
        .reset_n    (reset_n),
        .dp_rx      (dp_rx),
        .dn_rx      (dn_rx),
        .line_state (line)
    );

    // any line transition realigns the bit phase in the same cycle it is seen
    assign phase    = (line != line_prev_q) ? 2'd0 : phase_q;
    assign sample   = phase == 2'(SAMPLE_PHASE);
    assign jk       = (line == LS_J) || (line == LS_K);
    assign nrzi_bit = line == jk_prev_q;

    // receiver next-state and output-pulse decode, evaluated on sample strobes only
    always_comb begin
        state_d    = state_q;
        zeros_d    = zeros_q;
        ones_d     = ones_q;
        bits_d     = bits_q;
        sr_d       = sr_q;
        data_d     = data;
        jcnt_d     = (state_q == ERROR) ? jcnt_q : 4'd0;
        se0_seen_d = (state_q == ERROR) && se0_seen_q;
        active_d   = rx_active;
        start_d    = 1'b0;
        end_d      = 1'b0;
        err_d      = 1'b0;
        valid_d    = 1'b0;
        if (sample) begin
            case (state_q)
                IDLE: begin
                    if (line == LS_K) begin
                        state_d = SYNC;
                        zeros_d = 3'd1;
                    end
                end
                SYNC: begin
                    if (line == LS_SE0) begin
                        state_d = IDLE;
                    end else if (jk && !nrzi_bit) begin
                        zeros_d = (zeros_q == 3'd7) ? 3'd7 : zeros_q + 3'd1;
                    end else if (jk && zeros_q >= 3'(SYNC_ZEROS)) begin
                        state_d  = DATA;
                        start_d  = 1'b1;
                        active_d = 1'b1;
                        bits_d   = 3'd0;
                        ones_d   = 3'd0;
                    end else if (jk) begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    if (jk && ones_q == 3'(STUFF_ONES)) begin
                        ones_d   = 3'd0;
                        state_d  = nrzi_bit ? ERROR : DATA;
                        err_d    = nrzi_bit;
                        active_d = !nrzi_bit;
                    end else if (jk) begin
                        sr_d    = {nrzi_bit, sr_q[7:1]};
                        bits_d  = bits_q + 3'd1;
                        ones_d  = nrzi_bit ? ones_q + 3'd1 : 3'd0;
                        valid_d = bits_q == 3'd7;
                        data_d  = (bits_q == 3'd7) ? {nrzi_bit, sr_q[7:1]} : data;
                    end else if (line == LS_SE0) begin
                        state_d = EOP;
                    end else begin
                        state_d  = ERROR;
                        err_d    = 1'b1;
                        active_d = 1'b0;
                    end
                end
                EOP: begin
                    if (line != LS_SE0) begin
                        state_d  = IDLE;
                        active_d = 1'b0;
                        end_d    = (line == LS_J) && (bits_q == 3'd0);
                        err_d    = (line != LS_J) || (bits_q != 3'd0);
                    end
                end
                ERROR: begin
                    active_d = 1'b0;
                    if (line == LS_SE0) begin
                        se0_seen_d = 1'b1;
                        jcnt_d     = 4'd0;
                    end else if (line == LS_J) begin
                        jcnt_d  = jcnt_q + 4'd1;
                        state_d = (se0_seen_q || jcnt_q == 4'(IDLE_EXIT_J - 1)) ? IDLE : ERROR;
                    end else begin
                        se0_seen_d = 1'b0;
                        jcnt_d     = 4'd0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // state, DPLL and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            phase_q     <= 2'd0;
            line_prev_q <= LS_J;
            jk_prev_q   <= LS_J;
            zeros_q     <= 3'd0;
            ones_q      <= 3'd0;
            bits_q      <= 3'd0;
            sr_q        <= 8'd0;
            jcnt_q      <= 4'd0;
            se0_seen_q  <= 1'b0;
            rx_active   <= 1'b0;
            pkt_start   <= 1'b0;
            pkt_end     <= 1'b0;
            pkt_err     <= 1'b0;
            data        <= 8'd0;
            data_valid  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= (phase == 2'(OVERSAMPLE - 1)) ? 2'd0 : phase + 2'd1;
            line_prev_q <= line;
            jk_prev_q   <= (sample && jk) ? line : jk_prev_q;
            zeros_q     <= zeros_d;
            ones_q      <= ones_d;
            bits_q      <= bits_d;
            sr_q        <= sr_d;
            jcnt_q      <= jcnt_d;
            se0_seen_q  <= se0_seen_d;
            rx_active   <= active_d;
            pkt_start   <= start_d;
            pkt_end     <= end_d;
            pkt_err     <= err_d;
            data        <= data_d;
            data_valid  <= valid_d;
        end
    end
endmodule

// File: tb/tb_usb_fs_rx_phy.sv
// tb_usb_fs_rx_phy: packet-level checks of the full-speed receive front end
module tb_usb_fs_rx_phy;
    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LK   = 2'b01;
    localparam logic [1:0] LSE0 = 2'b00;

    typedef struct {
        string       name;
        int          nbits;
        logic [31:0] bits;
        bit          jit;
        bit          stuff;
        int          e_start;
        int          e_bytes;
        logic [31:0] e_data;
        int          e_end;
        int          e_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n, dp_rx, dn_rx;
    logic       rx_active, pkt_start, pkt_end, pkt_err, data_valid;
    logic [7:0] data;

    int         checks = 0, errors = 0;
    int         n_start = 0, n_end = 0, n_err = 0, viol = 0;
    logic [7:0] got[$];
    bit         in_pkt = 1'b0, rst_seen = 1'b0;
    int         b_start, b_end, b_err, b_got, b_viol;
    bit         jit, alt;
    vec_t       vt[7];
    int         nb;
    logic [31:0] rb;

    usb_fs_rx_phy dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dp_rx      (dp_rx),
        .dn_rx      (dn_rx),
        .rx_active  (rx_active),
        .pkt_start  (pkt_start),
        .pkt_end    (pkt_end),
        .pkt_err    (pkt_err),
        .data       (data),
        .data_valid (data_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rst_seen <= reset_n;

    // event recorder plus cycle-by-cycle protocol rules
    always @(negedge clk) begin
        if (!rst_seen) begin
            in_pkt = 1'b0;
            if (rx_active || pkt_start || pkt_end || pkt_err || data_valid) viol++;
        end else begin
            if (pkt_start) begin n_start++; in_pkt = 1'b1; end
            if (pkt_end || pkt_err) in_pkt = 1'b0;
            if (pkt_end) n_end++;
            if (pkt_err) n_err++;
            if (data_valid) got.push_back(data);
            if (pkt_end && pkt_err) viol++;
            if (data_valid && pkt_end) viol++;
            if (rx_active !== in_pkt) viol++;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic put(input logic [1:0] ls, input int cyc);
        {dp_rx, dn_rx} = ls;
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic put_bit(input logic [1:0] ls);
        put(ls, jit ? (alt ? 5 : 3) : 4);
        alt = !alt;
    endtask

    function automatic logic [1:0] flip(input logic [1:0] l);
        return (l == LJ) ? LK : LJ;
    endfunction

    // SYNC, NRZI-encoded payload (LSB first, optional stuffing), optional SE0 SE0 J EOP
    task automatic send_pkt(input int nbits, input logic [31:0] bits, input bit stuff, input bit eop);
        logic [1:0] lvl;
        int ones;
        lvl = LJ;
        for (int i = 0; i < 8; i++) begin
            if (i < 7) lvl = flip(lvl);
            put_bit(lvl);
        end
        ones = 0;
        for (int i = 0; i < nbits; i++) begin
            if (!bits[i]) lvl = flip(lvl);
            put_bit(lvl);
            ones = bits[i] ? ones + 1 : 0;
            if (stuff && ones == 6) begin
                lvl = flip(lvl);
                put_bit(lvl);
                ones = 0;
            end
        end
        if (eop) begin
            put_bit(LSE0);
            put_bit(LSE0);
            put_bit(LJ);
        end
    endtask

    task automatic mark();
        b_start = n_start; b_end = n_end; b_err = n_err; b_got = got.size(); b_viol = viol;
    endtask

    task automatic verify(input string nm, input int es, input int eb, input logic [31:0] ed,
                          input int ee, input int er);
        check({nm, "/starts"}, n_start - b_start, es);
        check({nm, "/bytes"}, got.size() - b_got, eb);
        for (int i = 0; i < eb; i++)
            check($sformatf("%s/byte%0d", nm, i),
                  (b_got + i < got.size()) ? int'(got[b_got + i]) : -1, int'(ed[8*i +: 8]));
        check({nm, "/ends"}, n_end - b_end, ee);
        check({nm, "/errs"}, n_err - b_err, er);
        check({nm, "/rules"}, viol - b_viol, 0);
    endtask

    initial begin
        vt[0] = '{"a5",     8,  32'hA5,     1'b0, 1'b1, 1, 1, 32'hA5,     1, 0};
        vt[1] = '{"ff",     8,  32'hFF,     1'b0, 1'b1, 1, 1, 32'hFF,     1, 0};
        vt[2] = '{"seven1", 8,  32'hFF,     1'b0, 1'b0, 1, 0, 32'h0,      0, 1};
        vt[3] = '{"bits12", 12, 32'h5A3,    1'b0, 1'b1, 1, 1, 32'hA3,     0, 1};
        vt[4] = '{"jit3b",  24, 32'h3C8001, 1'b1, 1'b1, 1, 3, 32'h3C8001, 1, 0};
        vt[5] = '{"jitstf", 16, 32'hFC7E,   1'b1, 1'b1, 1, 2, 32'hFC7E,   1, 0};
        vt[6] = '{"zero4",  32, 32'h0,      1'b0, 1'b1, 1, 4, 32'h0,      1, 0};

        reset_n = 1'b0;
        {dp_rx, dn_rx} = LJ;
        jit = 1'b0;
        alt = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst/rx_active", rx_active, 0);
        check("rst/pkt_start", pkt_start, 0);
        check("rst/pkt_end", pkt_end, 0);
        check("rst/pkt_err", pkt_err, 0);
        check("rst/data", data, 0);
        check("rst/data_valid", data_valid, 0);
        reset_n = 1'b1;
        put(LJ, 20);

        for (int v = 0; v < 7; v++) begin
            jit = vt[v].jit;
            mark();
            send_pkt(vt[v].nbits, vt[v].bits, vt[v].stuff, 1'b1);
            put(LJ, 40);
            verify(vt[v].name, vt[v].e_start, vt[v].e_bytes, vt[v].e_data, vt[v].e_end, vt[v].e_err);
        end

        jit = 1'b0;
        mark();
        send_pkt(8, 32'hFF, 1'b0, 1'b0);
        put(LJ, 7 * 4);
        send_pkt(8, 32'h11, 1'b1, 1'b1);
        put(LJ, 40);
        verify("err_7j", 1, 0, 32'h0, 0, 1);

        mark();
        send_pkt(8, 32'hFF, 1'b0, 1'b0);
        put(LJ, 8 * 4);
        send_pkt(8, 32'h11, 1'b1, 1'b1);
        put(LJ, 40);
        verify("err_8j", 2, 1, 32'h11, 1, 1);

        for (int r = 0; r < 16; r++) begin
            nb  = $urandom_range(8, 32);
            rb  = $urandom();
            jit = 1'($urandom_range(0, 1));
            mark();
            send_pkt(nb, rb, 1'b1, 1'b1);
            put(LJ, 40);
            verify($sformatf("rand%0d", r), 1, nb / 8, rb, (nb % 8 == 0) ? 1 : 0, (nb % 8 == 0) ? 0 : 1);
        end

        jit = 1'b0;
        send_pkt(4, 32'hA, 1'b1, 1'b0);
        put(LK, 2);
        check("mid/rx_active", rx_active, 1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("mid/rx_active", rx_active, 0);
        check("mid/data", data, 0);
        check("mid/pulses", {pkt_start, pkt_end, pkt_err, data_valid}, 0);
        mark();
        put(LSE0, 30000);
        put(LJ, 40);
        verify("busreset", 0, 0, 32'h0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
